// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity polarity constants and parity helper
//   state_e     : frame FSM states shared by the TX framer and RX path
//   PARITY_EVEN : parity bit = ^data
//   PARITY_ODD  : parity bit = ~^data
//   par()       : parity of a word of up to 8 bits (zero-extend narrower words)
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    function automatic logic par(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter 0..CLKS_PER_BIT-1
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : hold the counter at 0 (used while the line is idle)
//   bit_end_o  : high in the last clk of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic bit_end_o
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt_q, cnt_d;
    assign bit_end_o = cnt_q == W'(CLKS_PER_BIT - 1);
    assign cnt_d = (clr_i || bit_end_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one word per handshake as start + data (LSB first) + parity + stop bits
//   clk, rst  : clock, asynchronous active-high reset
//   tx_data   : word to send, captured on accept
//   tx_valid  : word available; accepted when tx_ready is high
//   tx_ready  : high only while idle
//   tx_out    : registered serial line, idle high
//   tx_busy   : frame in progress
//   tx_done   : one-clk pulse after the last stop bit
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);
    import uart_pkg::*;
    localparam int IW = $clog2(DATA_WIDTH);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic                  par_q, par_d;
    logic                  out_q, out_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    // Timer is parked at 0 while idle so every frame starts with a full start bit.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == IDLE),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (tx_valid) begin
                shreg_d = tx_data;
                par_d   = par(8'(tx_data), PARITY_ODD != 0);
                idx_d   = '0;
                stop_d  = 1'b0;
                state_d = START;
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(DATA_WIDTH - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: if (bit_end) begin
                stop_d = stop_q + 1'b1;
                if (stop_q == 1'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level is derived from the next state so tx_out can be a plain flop.
        out_d = (state_d == START)  ? 1'b0 :
                (state_d == DATA)   ? shreg_d[0] :
                (state_d == PARITY) ? par_d : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = state_q == IDLE;
    assign tx_busy  = ~tx_ready;
    assign tx_out   = out_q;
    assign tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frame checks on three parameterisations of uart_tx_frame
module tb_uart_tx_frame;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data [3];
    logic [2:0] valid, ready, out, busy, done;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
        .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d1 (
        .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) d2 (
        .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    // Sends w on DUT k and samples each of the 11 bit periods mid-bit.
    // Cycle c is the clk period after accept edge + c; done_at is the first cycle tx_done is seen.
    task automatic cap(input int k, input logic [7:0] w, output logic [10:0] bits,
                       output int done_at, output int lows, output int ready_hi);
        @(negedge clk);
        data[k]  = w;
        valid[k] = 1'b1;
        @(negedge clk);
        valid[k] = 1'b0;
        bits = '0; done_at = -1; lows = 0; ready_hi = 0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 4 == 2 && c / 4 < 11) bits[c / 4] = out[k];
            if (c < 44 && out[k] == 1'b0) lows++;
            if (c < 44 && ready[k]) ready_hi++;
            if (done[k] && done_at < 0) done_at = c;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; valid = '0;
        for (int i = 0; i < 3; i++) data[i] = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out !== 3'b111)   begin errors++; $display("FAIL reset_out got %b want 111", out); end
        checks++; if (ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b want 111", ready); end
        checks++; if (busy !== 3'b000)  begin errors++; $display("FAIL reset_busy got %b want 000", busy); end
        checks++; if (done !== 3'b000)  begin errors++; $display("FAIL reset_done got %b want 000", done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_even_a5;
        logic [10:0] b; int da, lo, rh;
        cap(0, 8'hA5, b, da, lo, rh);
        checks++; if (b !== 11'b10101001010) begin errors++; $display("FAIL a5_bits got %b want 10101001010", b); end
        checks++; if (da !== 44) begin errors++; $display("FAIL a5_done got %0d want 44", da); end
        checks++; if (rh !== 0)  begin errors++; $display("FAIL a5_ready_low got %0d ready cycles want 0", rh); end
    endtask

    task automatic test_odd;
        logic [10:0] b; int da, lo, rh;
        cap(1, 8'h00, b, da, lo, rh);
        checks++; if (b !== 11'b11000000000) begin errors++; $display("FAIL odd00_bits got %b want 11000000000", b); end
        checks++; if (da !== 44) begin errors++; $display("FAIL odd00_done got %0d want 44", da); end
        cap(1, 8'h01, b, da, lo, rh);
        checks++; if (b !== 11'b10000000010) begin errors++; $display("FAIL odd01_bits got %b want 10000000010", b); end
    endtask

    task automatic test_two_stop;
        logic [10:0] b; int da, lo, rh;
        cap(2, 8'hFF, b, da, lo, rh);
        checks++; if (b !== 11'b11111111110) begin errors++; $display("FAIL ff_bits got %b want 11111111110", b); end
        checks++; if (da !== 44) begin errors++; $display("FAIL ff_done got %0d want 44", da); end
        checks++; if (lo !== 4)  begin errors++; $display("FAIL ff_low_cycles got %0d want 4", lo); end
    endtask

    task automatic test_back_to_back;
        logic smp [100];
        logic [10:0] f1, f2;
        int da = -1, db = -1;
        logic busy45 = 1'b0;
        @(negedge clk);
        data[0] = 8'h3C; valid[0] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            smp[c] = out[0];
            if (c == 5) data[0] = 8'hC3;
            if (c == 45) begin valid[0] = 1'b0; busy45 = busy[0]; end
            if (done[0] && da < 0) da = c;
            else if (done[0] && da >= 0 && c > da + 1 && db < 0) db = c;
        end
        for (int i = 0; i < 11; i++) begin f1[i] = smp[4 * i + 2]; f2[i] = smp[45 + 4 * i + 2]; end
        checks++; if (f1 !== 11'b10001111000) begin errors++; $display("FAIL b2b_first got %b want 10001111000", f1); end
        checks++; if (f2 !== 11'b10110000110) begin errors++; $display("FAIL b2b_second got %b want 10110000110", f2); end
        checks++; if (da !== 44) begin errors++; $display("FAIL b2b_done1 got %0d want 44", da); end
        checks++; if (db !== 89) begin errors++; $display("FAIL b2b_done2 got %0d want 89", db); end
        checks++; if ({smp[44], smp[45], busy45} !== 3'b101)
            begin errors++; $display("FAIL b2b_contig got %b want 101", {smp[44], smp[45], busy45}); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] b; int da, lo, rh;
        int dn = 0;
        logic pre;
        @(negedge clk);
        data[0] = 8'h55; valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        pre = out[0];
        rst = 1'b1;
        #1;
        checks++; if (pre !== 1'b0) begin errors++; $display("FAIL rst_pre_bit3 got %b want 0", pre); end
        checks++; if ({out[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL rst_async got %b want 10", {out[0], busy[0]}); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done[0] || !out[0]) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rst_no_done got %0d active cycles want 0", dn); end
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready[0]); end
        cap(0, 8'h0F, b, da, lo, rh);
        checks++; if (b !== 11'b10000011110) begin errors++; $display("FAIL rst_next_bits got %b want 10000011110", b); end
        checks++; if (da !== 44) begin errors++; $display("FAIL rst_next_done got %0d want 44", da); end
    endtask

    task automatic test_scoreboard;
        logic [10:0] b; int da, lo, rh;
        logic [7:0] w;
        logic odd, perr, perr_flip;
        for (int i = 0; i < 9; i++) begin
            w = 8'($urandom_range(0, 255));
            cap(i % 3, w, b, da, lo, rh);
            odd = (i % 3 == 1);
            checks++; if (b[8:1] !== w) begin errors++; $display("FAIL sb_data[%0d] got %h want %h", i, b[8:1], w); end
            if (i % 3 == 2) begin
                checks++; if (b[10:9] !== 2'b11) begin errors++; $display("FAIL sb_stop2[%0d] got %b want 11", i, b[10:9]); end
            end else begin
                perr      = b[9] ^ (^w) ^ odd;
                perr_flip = ~b[9] ^ (^w) ^ odd;
                checks++; if (perr !== 1'b0) begin errors++; $display("FAIL sb_parity_err[%0d] got %b want 0", i, perr); end
                checks++; if (perr_flip !== 1'b1) begin errors++; $display("FAIL sb_flip_err[%0d] got %b want 1", i, perr_flip); end
                checks++; if (b[10] !== 1'b1) begin errors++; $display("FAIL sb_stop[%0d] got %b want 1", i, b[10]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_a5();
        test_odd();
        test_two_stop();
        test_back_to_back();
        test_reset_mid();
        test_scoreboard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
